// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter: round-robin share of one Avalon-style memory port between fetch and data
module mips_cpu_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_address,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_readdata,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_readdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                busy,
  output logic                bus_error
);
  localparam int CW = WAIT_LIMIT > 0 ? $clog2(WAIT_LIMIT + 1) : 1;
  typedef enum logic {IDLE, BUS} state_t;
  state_t          state;
  logic            grant_d, last_d;
  logic [CW-1:0]   wcnt;
  logic            i_elig, d_elig, pick_d, timeout;
  logic [DATA_W-1:0] rdata;
  assign i_elig  = i_req && !i_ack;
  assign d_elig  = d_req && !d_ack;
  assign pick_d  = d_elig && (!i_elig || !last_d);
  assign timeout = WAIT_LIMIT > 0 && wcnt == CW'(WAIT_LIMIT - 1);
  assign rdata   = mem_waitrequest ? '0 : mem_readdata;
  assign busy    = state == BUS;
  // arbitration, bus transfer and completion/abort handling
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant_d        <= 1'b0;
      last_d         <= 1'b1;
      wcnt           <= '0;
      i_ack          <= 1'b0;
      d_ack          <= 1'b0;
      i_readdata     <= '0;
      d_readdata     <= '0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      bus_error      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (state == IDLE) begin
        if (i_elig || d_elig) begin
          state          <= BUS;
          grant_d        <= pick_d;
          last_d         <= pick_d;
          wcnt           <= '0;
          mem_address    <= pick_d ? d_address : i_address;
          mem_read       <= !pick_d || !d_write;
          mem_write      <= pick_d && d_write;
          mem_byteenable <= pick_d ? d_byteenable : '1;
          if (pick_d) mem_writedata <= d_writedata;
        end
      end else if (!mem_waitrequest || timeout) begin
        state     <= IDLE;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (mem_waitrequest) bus_error <= 1'b1;
        if (grant_d) d_ack <= 1'b1;
        else i_ack <= 1'b1;
        if (mem_read && grant_d) d_readdata <= rdata;
        if (mem_read && !grant_d) i_readdata <= rdata;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb_mips_cpu_mem_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_mips_cpu_mem_arbiter;
  localparam logic [31:0] K = 32'hA5A5_A5A5;
  logic        clk = 1'b0, reset;
  logic        i_req, i_ack, d_req, d_write, d_ack;
  logic [31:0] i_address, i_readdata, d_address, d_writedata, d_readdata;
  logic [3:0]  d_byteenable, mem_byteenable;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest, busy, bus_error;
  logic [137:0] outs;
  typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] be;} bus_t;
  typedef struct packed {logic is_d; logic [31:0] rdata; logic [7:0] ncyc; logic err;} ack_t;
  bus_t bq[$];
  ack_t aq[$];
  int total = 0, bad = 0, wait_n = 0;
  logic exp_err = 1'b0;
  logic [31:0] exp_d_rd = '0;
  assign outs = {i_ack, i_readdata, d_ack, d_readdata, mem_address, mem_read, mem_write,
                 mem_writedata, mem_byteenable, busy, bus_error};
  mips_cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_readdata(i_readdata),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_readdata(d_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .busy(busy), .bus_error(bus_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not as required", nm);
  endtask
  task automatic exp_fetch(input logic [31:0] a, input int ncyc, input bit to);
    bq.push_back('{a, 1'b0, 32'h0, 4'hF});
    if (to) exp_err = 1'b1;
    aq.push_back('{1'b0, to ? 32'h0 : a ^ K, 8'(ncyc), exp_err});
  endtask
  task automatic exp_data(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int ncyc, input bit to);
    logic [31:0] r;
    r = w ? exp_d_rd : (to ? 32'h0 : a ^ K);
    if (!w) exp_d_rd = r;
    if (to) exp_err = 1'b1;
    bq.push_back('{a, w, wd, be});
    aq.push_back('{1'b1, r, 8'(ncyc), exp_err});
  endtask
  task automatic wait_ack(input logic d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d ? d_ack : i_ack) && n < 60);
    if (!(d ? d_ack : i_ack)) fail(d ? "d_ack_timeout" : "i_ack_timeout");
  endtask
  task automatic fetch(input logic [31:0] a, input int lat);
    int n;
    i_address = a;
    i_req = 1'b1;
    wait_ack(1'b0, n);
    i_req = 1'b0;
    chk("fetch_latency", 160'(n), 160'(lat));
  endtask
  task automatic dacc(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int lat);
    int n;
    d_write = w;
    d_address = a;
    d_writedata = wd;
    d_byteenable = be;
    d_req = 1'b1;
    wait_ack(1'b1, n);
    d_req = 1'b0;
    chk("data_latency", 160'(n), 160'(lat));
  endtask
  task automatic contest(input bit d_first, input logic [31:0] ia, input logic [31:0] da);
    @(negedge clk);
    if (d_first) begin
      exp_data(1'b0, da, 32'h0, 4'hC, 1, 0);
      exp_fetch(ia, 1, 0);
    end else begin
      exp_fetch(ia, 1, 0);
      exp_data(1'b0, da, 32'h0, 4'hC, 1, 0);
    end
    fork
      fetch(ia, d_first ? 4 : 2);
      dacc(1'b0, da, 32'h0, 4'hC, d_first ? 2 : 4);
    join
  endtask
  // slave model: stall the first wait_n strobe cycles, return address-derived data
  initial begin
    int wc = 0;
    mem_waitrequest = 1'b0;
    mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        mem_waitrequest = wc < wait_n;
        wc++;
      end else begin
        wc = 0;
        mem_waitrequest = 1'b0;
      end
      mem_readdata = mem_address ^ K;
    end
  end
  // monitor: checks bus requests and acks against the scoreboard queues
  initial begin
    bus_t e, cur;
    ack_t a;
    int scnt = 0;
    logic strobe, pstrobe = 1'b0, pack = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      strobe = mem_read || mem_write;
      if (strobe && !pstrobe) begin
        if (bq.size() == 0) fail("bus_unexpected");
        else begin
          e = bq.pop_front();
          chk("bus_addr", 160'(mem_address), 160'(e.addr));
          chk("bus_kind", {mem_read, mem_write, busy}, {!e.wr, e.wr, 1'b1});
          chk("bus_be", 160'(mem_byteenable), 160'(e.be));
          if (e.wr) chk("bus_wdata", 160'(mem_writedata), 160'(e.wdata));
        end
        cur = '{mem_address, mem_write, mem_writedata, mem_byteenable};
        scnt = 1;
      end else if (strobe) begin
        scnt++;
        chk("bus_hold", {mem_address, mem_write, mem_writedata, mem_byteenable}, cur);
      end
      if (i_ack || d_ack) begin
        if (aq.size() == 0) fail("ack_unexpected");
        else begin
          a = aq.pop_front();
          chk("ack_port", {i_ack, d_ack}, a.is_d ? 2'b01 : 2'b10);
          chk("ack_rdata", 160'(a.is_d ? d_readdata : i_readdata), 160'(a.rdata));
          chk("ack_strobe_len", 160'(scnt), 160'(a.ncyc));
          chk("ack_timing", {pstrobe, strobe, busy, pack}, 4'b1000);
          chk("ack_bus_error", bus_error, a.err);
        end
      end
      pstrobe = strobe;
      pack = i_ack || d_ack;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    reset = 1'b1;
    {i_req, d_req, d_write} = '0;
    i_address = '0;
    d_address = '0;
    d_writedata = '0;
    d_byteenable = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 160'(outs), 160'(0));
    reset = 1'b0;
    @(negedge clk);
    exp_fetch(32'hBFC0_0000, 1, 0);
    fetch(32'hBFC0_0000, 2);
    chk("t1_fetch_data", 160'(i_readdata), 160'(32'hBFC0_0000 ^ K));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    contest(1'b0, 32'h0000_0100, 32'h0000_2000);
    @(negedge clk);
    exp_fetch(32'h0000_0104, 1, 0);
    fetch(32'h0000_0104, 2);
    contest(1'b1, 32'h0000_0108, 32'h0000_2004);
    contest(1'b1, 32'h0000_010C, 32'h0000_2008);
    @(negedge clk);
    exp_data(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, 1, 0);
    dacc(1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, 2);
    contest(1'b0, 32'h0000_0110, 32'h0000_200C);
    @(negedge clk);
    wait_n = 3;
    exp_data(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'h3, 4, 0);
    dacc(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'h3, 5);
    chk("t3_d_readdata_kept", 160'(d_readdata), 160'(32'h0000_200C ^ K));
    @(negedge clk);
    wait_n = 1000;
    exp_fetch(32'h0000_0200, 4, 1);
    fetch(32'h0000_0200, 5);
    @(negedge clk);
    exp_data(1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'hF, 4, 1);
    dacc(1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'hF, 5);
    @(negedge clk);
    wait_n = 0;
    exp_data(1'b0, 32'h0000_5000, 32'h0, 4'hF, 1, 0);
    dacc(1'b0, 32'h0000_5000, 32'h0, 4'hF, 2);
    chk("t4_error_sticky", bus_error, 1'b1);
    @(negedge clk);
    wait_n = 1000;
    bq.push_back('{32'h0000_6000, 1'b0, 32'h0, 4'hF});
    d_write = 1'b0;
    d_address = 32'h0000_6000;
    d_byteenable = 4'hF;
    d_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_reset_midbus", 160'(outs), 160'(0));
    reset = 1'b0;
    exp_err = 1'b0;
    exp_d_rd = '0;
    wait_n = 0;
    repeat (4) @(negedge clk);
    exp_fetch(32'h0000_0400, 1, 0);
    exp_fetch(32'h0000_0404, 1, 0);
    i_address = 32'h0000_0400;
    i_req = 1'b1;
    wait_ack(1'b0, n);
    chk("t6_first_latency", 160'(n), 160'(2));
    i_address = 32'h0000_0404;
    @(negedge clk);
    chk("t6_no_grant_in_ack", 160'(mem_read), 160'(0));
    @(negedge clk);
    chk("t6_regrant", {mem_read, mem_address}, {1'b1, 32'h0000_0404});
    wait_ack(1'b0, n);
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("queues_drained", {32'(bq.size()), 32'(aq.size())}, 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
